// File: rtl/fpu_defs.sv
// Shared definitions for the iterative FPU multiplier: controller state type and
// the iteration-count helper used to size the datapath.
package fpu_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Number of radix steps needed to retire every bit of a (mant_w+1)-bit multiplier.
  function automatic int unsigned n_iter(input int unsigned mant_w,
                                         input int unsigned radix_bits);
    return (mant_w + radix_bits) / radix_bits;
  endfunction

endpackage

// File: rtl/fpu_mult_pp.sv
// Combinational partial product: one C_RADIX_BITS-wide multiplier digit times the
// full multiplicand mantissa.
module fpu_mult_pp #(
  parameter int unsigned C_MANT_W     = 23,
  parameter int unsigned C_RADIX_BITS = 4
) (
  input  logic [C_MANT_W:0]              mant,
  input  logic [C_RADIX_BITS-1:0]        bits,
  output logic [C_RADIX_BITS+C_MANT_W:0] prod
);

  localparam int unsigned PW = C_RADIX_BITS + C_MANT_W + 1;

  assign prod = PW'(mant) * PW'(bits);

endmodule

// File: rtl/fpu_mult_iter.sv
// Iterative pre-normalisation FP multiplier: retires C_RADIX_BITS multiplier bits per
// cycle into a full-width accumulator, with a valid/ready handshake on both sides.
module fpu_mult_iter
  import fpu_defs::*;
#(
  parameter int unsigned C_EXP_W      = 8,
  parameter int unsigned C_MANT_W     = 23,
  parameter int unsigned C_RADIX_BITS = 4
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RI,
  input  logic                        Flush_SI,
  input  logic                        In_Valid_SI,
  output logic                        In_Ready_SO,
  input  logic                        Sign_a_DI,
  input  logic                        Sign_b_DI,
  input  logic [C_EXP_W-1:0]          Exp_a_DI,
  input  logic [C_EXP_W-1:0]          Exp_b_DI,
  input  logic [C_MANT_W:0]           Mant_a_DI,
  input  logic [C_MANT_W:0]           Mant_b_DI,
  output logic                        Out_Valid_SO,
  input  logic                        Out_Ready_SI,
  output logic                        Sign_prenorm_DO,
  output logic signed [C_EXP_W+1:0]   Exp_prenorm_DO,
  output logic [2*C_MANT_W+1:0]       Mant_prenorm_DO
);

  localparam int unsigned M     = C_MANT_W + 1;
  localparam int unsigned ACC_W = 2 * M;
  localparam int unsigned EW    = C_EXP_W + 2;
  localparam int unsigned N     = n_iter(C_MANT_W, C_RADIX_BITS);
  localparam int unsigned PAD   = N * C_RADIX_BITS;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [EW-1:0] C_BIAS = EW'((1 << (C_EXP_W - 1)) - 1);

  mult_state_e                 state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [ACC_W-1:0]            acc_q;
  logic signed [EW-1:0]        exp_q;
  logic                        sign_q;
  logic                        valid_q;
  logic [M-1:0]                mant_a_q;
  logic [PAD-1:0]              b_shift_q;

  logic                        in_xfer;
  logic                        last_iter;
  logic signed [EW-1:0]        exp_sum;
  logic [31:0]                 shamt;
  logic [C_RADIX_BITS+M-1:0]   pp;
  logic [ACC_W-1:0]            pp_shifted;

  // Flush blocks acceptance so an operand set can never be swallowed by the abort.
  assign In_Ready_SO = !Flush_SI &&
                       ((state_q == IDLE) || ((state_q == DONE) && Out_Ready_SI));
  assign in_xfer     = In_Valid_SI && In_Ready_SO;
  assign last_iter   = (cnt_q == CNT_W'(N - 1));

  assign exp_sum    = $signed({2'b00, Exp_a_DI}) + $signed({2'b00, Exp_b_DI}) - C_BIAS;
  assign shamt      = 32'(cnt_q) * 32'(C_RADIX_BITS);
  assign pp_shifted = ACC_W'(pp) << shamt;

  fpu_mult_pp #(
    .C_MANT_W     (C_MANT_W),
    .C_RADIX_BITS (C_RADIX_BITS)
  ) u_pp (
    .mant (mant_a_q),
    .bits (b_shift_q[C_RADIX_BITS-1:0]),
    .prod (pp)
  );

  // NOTE: operand registers carry no reset; they are always reloaded before use and
  // nothing downstream observes them outside an accepted operation.
  always_ff @(posedge Clk_CI) begin
    if (in_xfer) begin
      mant_a_q  <= Mant_a_DI;
      b_shift_q <= PAD'(Mant_b_DI);
    end else if (state_q == BUSY) begin
      b_shift_q <= b_shift_q >> C_RADIX_BITS;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (Flush_SI) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else if (in_xfer) begin
      // Reachable from IDLE, or from DONE while the result is being taken.
      state_q <= BUSY;
      cnt_q   <= '0;
      acc_q   <= '0;
      exp_q   <= exp_sum;
      sign_q  <= Sign_a_DI ^ Sign_b_DI;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        BUSY: begin
          acc_q <= acc_q + pp_shifted;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (Out_Ready_SI) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Out_Valid_SO    = valid_q;
  assign Sign_prenorm_DO = sign_q;
  assign Exp_prenorm_DO  = exp_q;
  assign Mant_prenorm_DO = acc_q;

endmodule
